// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter that funnels single-beat register commands from NUM_REQ
// requesters onto one AXI4-Lite master port, one transaction at a time.
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  // Requester side: a command is taken in the IDLE cycle where
  // req_valid[i] & req_ready[i]; rsp_valid[i] pulses once when it completes.
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  // AXI4-Lite master: every channel transfers on the cycle where VALID & READY
  // are both high; our VALIDs are registered and never wait on READY to rise.
  output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
  output logic [2:0]                     M_AXI_AWPROT,
  output logic                           M_AXI_AWVALID,
  input  logic                           M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
  output logic                           M_AXI_WVALID,
  input  logic                           M_AXI_WREADY,
  input  logic [1:0]                     M_AXI_BRESP,
  input  logic                           M_AXI_BVALID,
  output logic                           M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
  output logic [2:0]                     M_AXI_ARPROT,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
  input  logic [1:0]                     M_AXI_RRESP,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  output logic [2:0]                     dbg_state
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         owner;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         cand;
  logic                  win_found;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating search that starts one past the previous winner, so a requester
  // that stays valid is reached within NUM_REQ grants.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = (last_grant == LAST_IDX) ? '0 : last_grant + GW'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + GW'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    if (!ARESET && state == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;
  assign dbg_state    = state;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      last_grant    <= LAST_IDX;
      owner         <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            last_grant <= win_idx;
            owner      <= win_idx;
            if (req_we[win_idx]) begin
              M_AXI_AWADDR  <= addr_arr[win_idx];
              M_AXI_WDATA   <= wdata_arr[win_idx];
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              M_AXI_ARADDR  <= addr_arr[win_idx];
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          // AW and W complete independently; leave once neither is outstanding.
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY     <= 1'b0;
            rsp_resp         <= M_AXI_BRESP;
            rsp_rdata        <= '0;
            rsp_valid[owner] <= 1'b1;
            state            <= IDLE;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY     <= 1'b0;
            rsp_rdata        <= M_AXI_RDATA;
            rsp_resp         <= M_AXI_RRESP;
            rsp_valid[owner] <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: two requesters against a 4x32 register
// slave model whose READY/VALID behaviour the sequences can reshape.
module tb_axi_lite_cmd_arbiter;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int W  = NR + DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot, dbg_state;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]    wdata, s_rdata;
  logic [3:0]       wstrb;

  // slave model controls
  logic        aw_rdy, w_rdy, ar_rdy, b_vld, r_vld, r_ovr;
  logic [1:0]  b_resp_v, r_resp_v;
  logic [31:0] ov_data;
  logic [31:0] mem [4];
  logic [3:0]  aw_q, ar_q;
  logic [31:0] w_q;
  logic        aw_got = 1'b0;
  logic        w_got  = 1'b0;
  logic        awhs, whs;

  axi_lite_cmd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(aw_rdy),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(w_rdy),
    .M_AXI_BRESP(b_resp_v), .M_AXI_BVALID(b_vld), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(ar_rdy),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(r_resp_v), .M_AXI_RVALID(r_vld), .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- register slave model ----------------
  assign awhs    = awvalid & aw_rdy;
  assign whs     = wvalid & w_rdy;
  assign s_rdata = r_ovr ? ov_data : mem[ar_q[3:2]];

  always @(posedge clk) begin
    if ((aw_got || awhs) && (w_got || whs)) begin
      mem[awhs ? awaddr[3:2] : aw_q[3:2]] <= whs ? wdata : w_q;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (awhs) begin aw_q <= awaddr; aw_got <= 1'b1; end
      if (whs)  begin w_q  <= wdata;  w_got  <= 1'b1; end
    end
    if (arvalid && ar_rdy) ar_q <= araddr;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL rsp_unexpected: got valid=%b rdata=%h resp=%b with nothing expected",
                 rsp_valid, rsp_rdata, rsp_resp);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rsp_valid, rsp_rdata, rsp_resp} !== exp_e) begin
          n_bad = n_bad + 1;
          $display("FAIL rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_resp}, exp_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NR-1:0] oh(input int r);
    logic [NR-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Presents one command, waits (bounded) for its grant, optionally queues the
  // expected response, and returns at the negedge after acceptance.
  task automatic issue(input int r, input logic we, input logic [3:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rdata,
                       input logic [1:0] exp_resp, input bit push);
    bit got;
    got = 1'b0;
    req_we[r]             = we;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = data;
    req_valid[r]          = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (req_ready[r]) got = 1'b1;
      else @(negedge clk);
    end
    check("grant", 64'(req_ready), 64'(oh(r)));
    if (push) exp_q.push_back({oh(r), exp_rdata, exp_resp});
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int          r;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl [8];

  int ng;
  int gcnt [NR];
  bit hit;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{r:0, we:1'b1, addr:4'h0, wdata:32'h1, exp_rdata:32'h0, exp_resp:2'b00};
    tbl[1] = '{r:1, we:1'b1, addr:4'h4, wdata:32'h2, exp_rdata:32'h0, exp_resp:2'b00};
    tbl[2] = '{r:0, we:1'b1, addr:4'h8, wdata:32'h3, exp_rdata:32'h0, exp_resp:2'b00};
    tbl[3] = '{r:1, we:1'b1, addr:4'hC, wdata:32'h4, exp_rdata:32'h0, exp_resp:2'b00};
    tbl[4] = '{r:0, we:1'b0, addr:4'h0, wdata:32'h0, exp_rdata:32'h1, exp_resp:2'b00};
    tbl[5] = '{r:1, we:1'b0, addr:4'h4, wdata:32'h0, exp_rdata:32'h2, exp_resp:2'b00};
    tbl[6] = '{r:0, we:1'b0, addr:4'h8, wdata:32'h0, exp_rdata:32'h3, exp_resp:2'b00};
    tbl[7] = '{r:1, we:1'b0, addr:4'hC, wdata:32'h0, exp_rdata:32'h4, exp_resp:2'b00};

    aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; b_vld = 1'b1; r_vld = 1'b1;
    r_ovr = 1'b0; b_resp_v = 2'b00; r_resp_v = 2'b00; ov_data = 32'h0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;

    // reset values, with both requesters asserting to show no grant leaks out
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'd0);
    check("rst_handshakes", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rst_addr_data", 64'({awaddr, araddr, wdata}), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // single write, minimum latency
    issue(0, 1'b1, 4'h4, 32'h2, 32'h0, 2'b00, 1'b1);
    check("sw_c1_awv_wv", 64'({awvalid, wvalid}), 64'b11);
    check("sw_c1_awaddr", 64'(awaddr), 64'h4);
    check("sw_c1_wdata", 64'(wdata), 64'h2);
    check("sw_c1_strb_prot", 64'({wstrb, awprot, arprot}), 64'hF << 6);
    check("sw_c1_bready", 64'(bready), 64'd0);
    @(negedge clk);
    check("sw_c2_bready", 64'(bready), 64'd1);
    check("sw_c2_awv_wv", 64'({awvalid, wvalid}), 64'b00);
    check("sw_c2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("sw_c3_rsp_valid", 64'(rsp_valid), 64'b01);
    check("sw_c3_idle", 64'(dbg_state), 64'd0);
    wait_done();

    // table-driven writes then reads
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_resp, 1'b1);
      wait_done();
    end

    // both requesters continuously valid: strict alternation starting at 0
    req_we = 2'b00;
    req_addr[0 +: AW]  = 4'h0;
    req_addr[AW +: AW] = 4'h4;
    req_valid = 2'b11;
    ng = 0;
    gcnt[0] = 0;
    gcnt[1] = 0;
    for (int k = 0; k < 60 && ng < 6; k++) begin
      #1;
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), 64'(oh(ng % 2)));
        exp_q.push_back({oh(ng % 2), (ng % 2) ? 32'h2 : 32'h1, 2'b00});
        gcnt[ng % 2] = gcnt[ng % 2] + 1;
        if (gcnt[ng % 2] == 3) begin
          @(negedge clk);
          req_valid[ng % 2] = 1'b0;
        end else begin
          @(negedge clk);
        end
        ng = ng + 1;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = '0;
    check("rr_grant_count", 64'(ng), 64'd6);
    wait_done();

    // write with WREADY held off until cycle 4
    w_rdy = 1'b0;
    issue(1, 1'b1, 4'h8, 32'hA5A5_0003, 32'h0, 2'b00, 1'b1);
    check("dw_c1_awv_wv", 64'({awvalid, wvalid}), 64'b11);
    @(negedge clk);
    check("dw_c2_awv_wv", 64'({awvalid, wvalid}), 64'b01);
    check("dw_c2_bready", 64'(bready), 64'd0);
    @(negedge clk);
    check("dw_c3_awv_wv", 64'({awvalid, wvalid}), 64'b01);
    check("dw_c3_bready", 64'(bready), 64'd0);
    @(negedge clk);
    check("dw_c4_wvalid", 64'(wvalid), 64'd1);
    w_rdy = 1'b1;
    @(negedge clk);
    check("dw_c5_wvalid", 64'(wvalid), 64'd0);
    check("dw_c5_bready", 64'(bready), 64'd1);
    wait_done();
    issue(0, 1'b0, 4'h8, 32'h0, 32'hA5A5_0003, 2'b00, 1'b1);
    wait_done();

    // slave error on a read
    r_ovr = 1'b1; ov_data = 32'hDEAD_BEEF; r_resp_v = 2'b10;
    issue(0, 1'b0, 4'hC, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b1);
    wait_done();
    r_ovr = 1'b0; r_resp_v = 2'b00;
    repeat (2) @(negedge clk);
    check("err_hold_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    check("err_hold_resp", 64'(rsp_resp), 64'b10);

    // reset while waiting in WR_RESP
    b_vld = 1'b0;
    issue(0, 1'b1, 4'h0, 32'h55, 32'h0, 2'b00, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (bready) hit = 1'b1;
      else @(negedge clk);
    end
    check("mr_reached_wr_resp", 64'(bready), 64'd1);
    rst = 1'b1;
    #1;
    check("mr_handshakes", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("mr_state", 64'(dbg_state), 64'd0);
    check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    b_vld = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mr_hold_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mr_after_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mr_after_state", 64'(dbg_state), 64'd0);
    end

    // simultaneous request after reset: requester 0 first, then 1
    req_we = 2'b00;
    req_addr[0 +: AW]  = 4'h4;
    req_addr[AW +: AW] = 4'h8;
    req_valid = 2'b11;
    #1;
    check("post_rst_grant0", 64'(req_ready), 64'b01);
    exp_q.push_back({2'b01, 32'h2, 2'b00});
    @(negedge clk);
    req_valid[0] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      #1;
      if (req_ready[1]) hit = 1'b1;
      else @(negedge clk);
    end
    check("post_rst_grant1", 64'(req_ready), 64'b10);
    exp_q.push_back({2'b10, 32'hA5A5_0003, 2'b00});
    @(negedge clk);
    req_valid = '0;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
